// File: rtl/bus_cycle_unit.sv
// Converts single-transfer core requests into 8085-style multiplexed bus cycles
// (T1/T2/TW/T3) with READY wait states, a wait timeout and HOLD/HLDA arbitration.
module bus_cycle_unit #(
   parameter int MAX_WAIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic        io,
   input  logic        fetch,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic        ack,
   output logic        err,
   output logic [7:0]  rdata,
   output logic        busy,
   output logic [7:0]  ad_out,
   output logic        ad_oe,
   input  logic [7:0]  ad_in,
   output logic [7:0]  a_hi,
   output logic        ale,
   output logic        rd_n,
   output logic        wr_n,
   output logic        io_m,
   output logic [1:0]  s,
   input  logic        ready,
   input  logic        hold,
   output logic        hlda
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_TW   = 3'd3,
      S_T3   = 3'd4,
      S_HOLD = 3'd5
   } state_t;

   localparam int CNT_W = $clog2(MAX_WAIT + 2);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);

   state_t state_q, state_d;

   logic             we_q, we_d;
   logic             io_q, io_d;
   logic             fetch_q, fetch_d;
   logic [15:0]      addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic             tmo_q, tmo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;

   logic       ack_q, ack_d;
   logic       err_q, err_d;
   logic [7:0] rdata_q, rdata_d;
   logic       busy_q, busy_d;
   logic [7:0] ad_out_q, ad_out_d;
   logic       ad_oe_q, ad_oe_d;
   logic [7:0] a_hi_q, a_hi_d;
   logic       ale_q, ale_d;
   logic       rd_n_q, rd_n_d;
   logic       wr_n_q, wr_n_d;
   logic       io_m_q, io_m_d;
   logic [1:0] s_q, s_d;
   logic       hlda_q, hlda_d;

   // {S1,S0}: fetch 11, write 01, read 10
   function automatic logic [1:0] bus_status(input logic f, input logic w);
      if (w)      return 2'b01;
      else if (f) return 2'b11;
      else        return 2'b10;
   endfunction

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      io_d    = io_q;
      fetch_d = fetch_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      tmo_d   = tmo_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            // hold wins over req; a req during the ack pulse is the old one
            if (hold) begin
               state_d = S_HOLD;
            end else if (req && !ack_q) begin
               state_d = S_T1;
               we_d    = we;
               io_d    = io;
               fetch_d = fetch;
               addr_d  = addr;
               wdata_d = wdata;
               tmo_d   = 1'b0;
            end
         end
         S_T1: state_d = S_T2;
         S_T2: begin
            cnt_d   = '0;
            state_d = ready ? S_T3 : S_TW;
         end
         S_TW: begin
            cnt_d = cnt_inc;
            if (ready) begin
               state_d = S_T3;
            end else if ((MAX_WAIT != 0) && (cnt_inc == MAX_C)) begin
               state_d = S_T3;
               tmo_d   = 1'b1;
            end
         end
         S_T3:    state_d = S_IDLE;
         S_HOLD:  if (!hold) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered, so they are derived from the state being entered.
   always_comb begin
      ack_d    = 1'b0;
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      busy_d   = 1'b0;
      ad_out_d = ad_out_q;
      ad_oe_d  = 1'b0;
      a_hi_d   = a_hi_q;
      ale_d    = 1'b0;
      rd_n_d   = 1'b1;
      wr_n_d   = 1'b1;
      io_m_d   = io_m_q;
      s_d      = 2'b00;
      hlda_d   = 1'b0;
      case (state_d)
         S_T1: begin
            ale_d    = 1'b1;
            ad_out_d = addr_d[7:0];
            ad_oe_d  = 1'b1;
            a_hi_d   = addr_d[15:8];
            io_m_d   = io_d;
            s_d      = bus_status(fetch_d, we_d);
            busy_d   = 1'b1;
         end
         S_T2, S_TW, S_T3: begin
            busy_d = 1'b1;
            s_d    = s_q;
            if (we_q) begin
               wr_n_d   = 1'b0;
               ad_out_d = wdata_q;
               ad_oe_d  = 1'b1;
            end else begin
               rd_n_d   = 1'b0;
            end
         end
         S_HOLD: hlda_d = 1'b1;
         S_IDLE: begin
            if (state_q == S_T3) begin
               ack_d = 1'b1;
               err_d = tmo_q;
               if (!we_q) rdata_d = tmo_q ? 8'hFF : ad_in;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q     <= 1'b0;
         io_q     <= 1'b0;
         fetch_q  <= 1'b0;
         addr_q   <= 16'h0000;
         wdata_q  <= 8'h00;
         tmo_q    <= 1'b0;
         cnt_q    <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= 8'h00;
         busy_q   <= 1'b0;
         ad_out_q <= 8'h00;
         ad_oe_q  <= 1'b0;
         a_hi_q   <= 8'h00;
         ale_q    <= 1'b0;
         rd_n_q   <= 1'b1;
         wr_n_q   <= 1'b1;
         io_m_q   <= 1'b0;
         s_q      <= 2'b00;
         hlda_q   <= 1'b0;
      end else begin
         we_q     <= we_d;
         io_q     <= io_d;
         fetch_q  <= fetch_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         tmo_q    <= tmo_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         busy_q   <= busy_d;
         ad_out_q <= ad_out_d;
         ad_oe_q  <= ad_oe_d;
         a_hi_q   <= a_hi_d;
         ale_q    <= ale_d;
         rd_n_q   <= rd_n_d;
         wr_n_q   <= wr_n_d;
         io_m_q   <= io_m_d;
         s_q      <= s_d;
         hlda_q   <= hlda_d;
      end
   end

   assign ack    = ack_q;
   assign err    = err_q;
   assign rdata  = rdata_q;
   assign busy   = busy_q;
   assign ad_out = ad_out_q;
   assign ad_oe  = ad_oe_q;
   assign a_hi   = a_hi_q;
   assign ale    = ale_q;
   assign rd_n   = rd_n_q;
   assign wr_n   = wr_n_q;
   assign io_m   = io_m_q;
   assign s      = s_q;
   assign hlda   = hlda_q;

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Bench for bus_cycle_unit: each transfer's expected bus timeline is built from
// its phase count (T1, T2 + waits, T3, ack) and compared cycle by cycle.
module tb_bus_cycle_unit;

   localparam int MW = 3;

   logic        clk = 1'b0;
   logic        rst, req, we, io, fetch, ready, hold;
   logic [15:0] addr;
   logic [7:0]  wdata, ad_in;
   logic        ack, err, busy, ad_oe, ale, rd_n, wr_n, io_m, hlda;
   logic [7:0]  rdata, ad_out, a_hi;
   logic [1:0]  s;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] rd_exp = 8'h00;

   bus_cycle_unit #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .io(io), .fetch(fetch),
      .addr(addr), .wdata(wdata), .ack(ack), .err(err), .rdata(rdata),
      .busy(busy), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .a_hi(a_hi),
      .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .io_m(io_m), .s(s),
      .ready(ready), .hold(hold), .hlda(hlda)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (vectors=%0d)", vectors);
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      logic [34:0] got, want;
      got  = {ack, err, rdata, busy, ad_out, ad_oe, a_hi, ale, rd_n, wr_n, io_m, s, hlda};
      want = {1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s outputs got %h want %h", tag, got, want);
      end
   endtask

   // One transfer. nz = READY-low samples starting at T2; ign = req first raised
   // during an ack pulse; chain = return on the ack cycle; hold_t2 = raise hold in T2.
   task automatic run_txn(input logic t_we, input logic t_io, input logic t_fetch,
                          input logic [15:0] t_addr, input logic [7:0] t_wd,
                          input int nz, input bit ign, input bit chain, input bit hold_t2);
      int tw, zused;
      bit tmo, act, inb;
      logic [1:0] st;
      logic [7:0] t3_in, exp_c, got_c;
      tmo = (MW != 0) && (nz > MW);
      tw  = tmo ? MW : nz;
      st  = t_we ? 2'b01 : (t_fetch ? 2'b11 : 2'b10);
      req = 1'b1; we = t_we; io = t_io; fetch = t_fetch; addr = t_addr; wdata = t_wd;
      ready = 1'b1; ad_in = 8'($urandom);
      if (ign) begin
         step();
         vectors++;
         if ({ale, busy, ack} !== 3'b000) begin
            miscompares++;
            $display("FAIL req_during_ack ale,busy,ack got %b want 000", {ale, busy, ack});
         end
      end
      zused = 0;
      t3_in = 8'h00;
      for (int c = 1; c <= 4 + tw; c++) begin
         step();
         act = (c >= 2) && (c <= 3 + tw);
         inb = (c <= 3 + tw);
         if (c == 4 + tw && !t_we) rd_exp = tmo ? 8'hFF : t3_in;
         exp_c = {c == 1, inb, !(act && !t_we), !(act && t_we), (c == 1) || (act && t_we),
                  1'b0, c == 4 + tw, (c == 4 + tw) && tmo};
         got_c = {ale, busy, rd_n, wr_n, ad_oe, hlda, ack, err};
         vectors++;
         if (got_c !== exp_c) begin
            miscompares++;
            $display("FAIL ctl addr=%h cyc=%0d ale,busy,rd_n,wr_n,ad_oe,hlda,ack,err got %b want %b",
                     t_addr, c, got_c, exp_c);
         end
         vectors++;
         if (s !== (inb ? st : 2'b00)) begin
            miscompares++;
            $display("FAIL status addr=%h cyc=%0d got %b want %b", t_addr, c, s, inb ? st : 2'b00);
         end
         vectors++;
         if (rdata !== rd_exp) begin
            miscompares++;
            $display("FAIL rdata addr=%h cyc=%0d got %h want %h", t_addr, c, rdata, rd_exp);
         end
         if (inb) begin
            vectors++;
            if ({a_hi, io_m} !== {t_addr[15:8], t_io}) begin
               miscompares++;
               $display("FAIL a_hi/io_m cyc=%0d got %h/%b want %h/%b", c, a_hi, io_m, t_addr[15:8], t_io);
            end
         end
         if (c == 1 || (act && t_we)) begin
            vectors++;
            if (ad_out !== ((c == 1) ? t_addr[7:0] : t_wd)) begin
               miscompares++;
               $display("FAIL ad_out cyc=%0d got %h want %h", c, ad_out, (c == 1) ? t_addr[7:0] : t_wd);
            end
         end
         if (c == 1) begin
            req = 1'b0; we = 1'($urandom_range(0, 1)); io = 1'($urandom_range(0, 1));
            fetch = 1'($urandom_range(0, 1)); addr = 16'($urandom); wdata = 8'($urandom);
         end
         if (c == 2 && hold_t2) hold = 1'b1;
         if (c >= 2 && zused < nz) begin
            ready = 1'b0;
            zused++;
         end else begin
            ready = 1'b1;
         end
         ad_in = 8'($urandom);
         if (c == 3 + tw) t3_in = ad_in;
      end
      if (!chain) begin
         step();
         vectors++;
         if ({ack, busy, s} !== 4'b0000) begin
            miscompares++;
            $display("FAIL ack_pulse ack,busy,s got %b want 0000", {ack, busy, s});
         end
      end
   endtask

   task automatic check_hold_vals(input string tag);
      logic [6:0] got;
      got = {hlda, ad_oe, rd_n, wr_n, ale, s};
      vectors++;
      if (got !== 7'b1011000) begin
         miscompares++;
         $display("FAIL %s hlda,ad_oe,rd_n,wr_n,ale,s got %b want 1011000", tag, got);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b0; we = 1'b0; io = 1'b0; fetch = 1'b0; addr = 16'h0;
      wdata = 8'h0; ad_in = 8'h0; ready = 1'b1; hold = 1'b0;
      repeat (3) step();
      check_reset_vals("reset");
      rst = 1'b0;
      step();
      check_reset_vals("post_reset_idle");
   endtask

   task automatic test_zero_wait_read();
      run_txn(1'b0, 1'b0, 1'b0, 16'h2050, 8'h00, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_io_write_waits();
      run_txn(1'b1, 1'b1, 1'b0, 16'h0081, 8'h3C, 2, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_fetch();
      run_txn(1'b0, 1'b0, 1'b1, 16'($urandom), 8'h00, 0, 1'b0, 1'b0, 1'b0);
      run_txn(1'b0, 1'b0, 1'b1, 16'($urandom), 8'h00, 1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_timeout();
      run_txn(1'b0, 1'b0, 1'b0, 16'h1234, 8'h00, 8, 1'b0, 1'b0, 1'b0);
      run_txn(1'b1, 1'b0, 1'b0, 16'hBEEF, 8'h77, 4, 1'b0, 1'b0, 1'b0);
      run_txn(1'b0, 1'b1, 1'b0, 16'h00F0, 8'h00, MW, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++)
         run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom), 8'($urandom), $urandom_range(0, 5), 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run_txn(1'b0, 1'b0, 1'b0, 16'h4411, 8'h00, 0, 1'b0, 1'b1, 1'b0);
      run_txn(1'b1, 1'b0, 1'b0, 16'h5522, 8'hA1, 1, 1'b1, 1'b1, 1'b0);
      run_txn(1'b0, 1'b1, 1'b1, 16'h6633, 8'h00, 0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_hold();
      hold = 1'b1;
      step();
      check_hold_vals("hold_from_idle");
      step();
      check_hold_vals("hold_stay");
      hold = 1'b0;
      step();
      vectors++;
      if ({hlda, busy} !== 2'b00) begin
         miscompares++;
         $display("FAIL hold_release hlda,busy got %b want 00", {hlda, busy});
      end
      run_txn(1'b0, 1'b0, 1'b0, 16'h7788, 8'h00, 1, 1'b0, 1'b1, 1'b1);
      step();
      check_hold_vals("hold_after_cycle");
      req = 1'b1; we = 1'b0; addr = 16'h9999;
      repeat (2) begin
         step();
         check_hold_vals("hold_with_req");
         vectors++;
         if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_with_req busy got %b want 0", busy);
         end
      end
      hold = 1'b0;
      step();
      vectors++;
      if ({hlda, ale, busy} !== 3'b000) begin
         miscompares++;
         $display("FAIL hold_drop hlda,ale,busy got %b want 000", {hlda, ale, busy});
      end
      run_txn(1'b1, 1'b1, 1'b0, 16'h0A0B, 8'h5A, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      req = 1'b1; we = 1'b0; io = 1'b1; fetch = 1'b0; addr = 16'hC3D4; ready = 1'b1;
      step();
      req = 1'b0; ready = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      check_reset_vals("reset_mid_cycle");
      rd_exp = 8'h00;
      rst = 1'b0; ready = 1'b1;
      repeat (3) begin
         step();
         vectors++;
         if ({ack, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL after_reset ack,busy got %b want 00", {ack, busy});
         end
      end
      run_txn(1'b0, 1'b0, 1'b0, 16'hE0E1, 8'h00, 1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_zero_wait_read();
      test_io_write_waits();
      test_fetch();
      test_timeout();
      test_back_to_back();
      test_hold();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bus_cycle_unit.md
# bus_cycle_unit

Bus cycle unit that converts single-transfer requests from the MP85 core into 8085-style multiplexed bus cycles (T1/T2/TW/T3) with ALE, RD_n, WR_n, IO/M and S1/S0 status, READY-driven wait states, a wait timeout and HOLD/HLDA arbitration. It sits directly downstream of the core's memory port, replacing the zero-wait internal memory path when the CPU talks to external memory or I/O.

## Interface
- MAX_WAIT, 15: max consecutive TW cycles before the cycle is forced to end with err; 0 disables the timeout.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  core transfer request; level, sampled in IDLE only.
- we  input  1  1 = write, 0 = read; sampled with req.
- io  input  1  1 = I/O cycle, 0 = memory; sampled with req.
- fetch  input  1  1 = opcode fetch (read only); sampled with req.
- addr  input  16  transfer address; sampled with req.
- wdata  input  8  write data; sampled with req.
- ack  output  1  one-cycle pulse: transfer complete.
- err  output  1  valid with ack: 1 = ended by wait timeout.
- rdata  output  8  read data; updated only when a read completes, held otherwise.
- busy  output  1  1 from T1 through T3.
- ad_out  output  8  multiplexed AD7..0 drive value.
- ad_oe  output  1  AD7..0 output enable.
- ad_in  input  8  AD7..0 bus input.
- a_hi  output  8  A15..8.
- ale  output  1  address latch enable.
- rd_n  output  1  read strobe, active low.
- wr_n  output  1  write strobe, active low.
- io_m  output  1  1 = I/O, 0 = memory.
- s  output  2  status {S1,S0}: 11 fetch, 10 read, 01 write, 00 idle/hold.
- ready  input  1  external READY; 0 inserts wait states.
- hold  input  1  external bus request.
- hlda  output  1  hold acknowledge.

## Operation
- States: IDLE, T1, T2, TW, T3, HOLD. All outputs are registered.
- Reset values: state IDLE, ack 0, err 0, rdata 00, busy 0, ad_out 00, ad_oe 0, a_hi 00, ale 0, rd_n 1, wr_n 1, io_m 0, s 00, hlda 0, wait count 0.
- IDLE: if hold = 1, go to HOLD; hold has priority over req. Else if req = 1 and ack = 0, latch we/io/fetch/addr/wdata and go to T1. A req seen while ack = 1 is ignored; the core drops req on ack.
- T1: ale 1, ad_out = addr[7:0], ad_oe 1, a_hi = addr[15:8], io_m and s valid, busy 1. s = 11 if fetch & !we, 01 if we, else 10. Always go to T2.
- T2: ale 0, a_hi/io_m/s held. Read: rd_n 0, ad_oe 0. Write: wr_n 0, ad_out = wdata, ad_oe 1. Clear the wait count. Go to T3 if ready = 1, else to TW.
- TW: strobes and bus held as in T2; the wait count increments each TW cycle.
  - ready = 1: go to T3.
  - ready = 0 and count = MAX_WAIT (MAX_WAIT ≠ 0): go to T3 with the timeout flag set.
  - Otherwise stay in TW.
- T3: strobes held active. At the end of T3:
  - Read: rdata <= ad_in, or rdata <= FF on timeout.
  - Deassert rd_n/wr_n, ad_oe 0, s 00, busy 0.
  - Pulse ack for one cycle with err = timeout flag.
  - Return to IDLE.
- HOLD: hlda 1, ad_oe 0, rd_n 1, wr_n 1, ale 0, s 00. Stay while hold = 1. When hold drops, hlda goes 0 on the next edge and the state returns to IDLE. hold is never sampled mid-cycle; a running cycle always finishes first.
- Synchronous reset at any state, including mid-cycle: next edge applies reset values. No ack is issued for the aborted cycle.

## Timing
- Zero-wait read: req seen in cycle 0 (IDLE). Cycles 1/2/3 are T1/T2/T3. Cycle 4 shows ack = 1 with rdata valid and the state back in IDLE.
- Each wait state adds exactly one cycle. Minimum request-to-request spacing is 5 cycles.
- ale is high for exactly the T1 cycle. Strobes are low for T2 + TW + T3.
- Write data is driven from T2 through T3. The bus is not driven (ad_oe 0) during read T2..T3.
- Timeout: with ready held 0, the bus shows T2, then MAX_WAIT TW cycles, then T3. ack/err follow one cycle after T3.
- hold asserted in IDLE: hlda = 1 on the second cycle. hold dropped: hlda = 0 one cycle later. A new T1 may start one cycle after that.

## Test plan
- Zero-wait memory read: addr 2050, ad_in A5 in T3 -> ale cycle 1, a_hi 20, ad_out 50, s 10, rd_n low cycles 2-3, ack + rdata A5 at cycle 4, err 0.
- I/O write with 2 waits: addr 0081, wdata 3C, io 1, ready 0 for 2 sampled cycles -> io_m 1, s 01, ad_out 3C during T2/TW/TW/T3, wr_n low 4 cycles, ack at cycle 6.
- Opcode fetch: fetch 1, we 0 -> s 11, rd_n low, rdata = ad_in.
- Timeout: MAX_WAIT 3, ready stuck 0 -> exactly 3 TW cycles, then T3, then ack = 1, err = 1, rdata FF.
- HOLD: hold raised during T2 of a read -> cycle completes normally, then HOLD with hlda 1 and all strobes inactive. A req raised during HOLD starts T1 only after hold drops and hlda clears.
- Reset mid-cycle: rst in TW -> next cycle all outputs at reset values, no ack. A subsequent req runs a normal cycle.
